mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: two-entry skid buffer (head + skid) feeding the register
// file and PC, with forwarding of the youngest pending register write and a retire counter.
`timescale 1ns/1ps
module mem_wb_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      ReadData,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic [3:0]       WA3,
  input  logic             flush,
  input  logic             wb_ready,
  output logic             wb_valid,
  output logic [31:0]      Result,
  output logic [3:0]       WA3_out,
  output logic             WE3,
  output logic             PCWrite,
  output logic             fwd_valid,
  output logic [3:0]       fwd_reg,
  output logic [31:0]      fwd_data,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam logic [RW-1:0] PC_REG = RW'(15);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] result;
    logic [RW-1:0] wa3;
    logic          rw;
  } entry_t;

  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  entry_t           new_entry;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             accept;
  logic             retire;

  assign accept = in_valid && !skid_q.valid;
  assign retire = head_q.valid && wb_ready;

  // Write-back value is resolved at capture so the head holds a single result.
  always_comb begin
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.result = MemtoReg ? ReadData : ALUResult;
    new_entry.wa3    = WA3;
    new_entry.rw     = RegWrite;
  end

  always_comb begin
    head_d    = head_q;
    skid_d    = skid_q;
    retired_d = retired_q;
    if (flush) begin
      head_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else begin
      if (retire) begin
        retired_d = retired_q + CNT_W'(1);
        if (skid_q.valid) begin
          head_d = skid_q;
        end else begin
          head_d.valid = 1'b0;
        end
        skid_d.valid = 1'b0;
      end
      // Accept lands in the head only if it is free after this edge's retire.
      if (accept) begin
        if (!head_d.valid) begin
          head_d = new_entry;
        end else begin
          skid_d = new_entry;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      skid_q    <= '0;
      retired_q <= '0;
    end else begin
      head_q    <= head_d;
      skid_q    <= skid_d;
      retired_q <= retired_d;
    end
  end

  assign in_ready = !skid_q.valid;
  assign wb_valid = head_q.valid;
  assign Result   = head_q.result;
  assign WA3_out  = head_q.wa3;
  assign retired  = retired_q;
  assign WE3      = retire && head_q.rw && (head_q.wa3 != PC_REG);
  assign PCWrite  = retire && head_q.rw && (head_q.wa3 == PC_REG);

  // Youngest pending GPR write wins; R15 writes are never forwarded.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_reg   = '0;
    fwd_data  = '0;
    if (skid_q.valid && skid_q.rw && (skid_q.wa3 != PC_REG)) begin
      fwd_valid = 1'b1;
      fwd_reg   = skid_q.wa3;
      fwd_data  = skid_q.result;
    end else if (head_q.valid && head_q.rw && (head_q.wa3 != PC_REG)) begin
      fwd_valid = 1'b1;
      fwd_reg   = head_q.wa3;
      fwd_data  = head_q.result;
    end
  end

endmodule
